// File: rtl/bingo_board_engine.sv
// One NxN bingo board: number placement, circling from local/peer calls, line counting.
// Optional BINGO_AUTOFILL_EN: cur_number==0 in SELECT fills remaining cells with lowest free numbers.
module bingo_board_engine #(
    parameter int N         = 5,
    parameter int NUM_W     = 5,
    parameter int WIN_LINES = 3,
    localparam int CELLS    = N * N,
    localparam int LW       = $clog2(2 * N + 3)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     interboard_rst,
    input  logic                     start,
    input  logic                     enter_pulse,
    input  logic [NUM_W-1:0]         cur_number,
    input  logic                     rx_en,
    input  logic [NUM_W-1:0]         rx_number,
    input  logic                     tx_ready,
    output logic                     tx_en,
    output logic [NUM_W-1:0]         tx_number,
    output logic [CELLS*NUM_W-1:0]   map,
    output logic [CELLS-1:0]         circle,
    output logic [LW-1:0]            lines,
    output logic                     win,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        PLAY   = 3'd2,
        CHECK  = 3'd3,
        WIN    = 3'd4
    } state_t;

    localparam int PW = $clog2(CELLS + 1);
    localparam int NV = 2 ** NUM_W;
    localparam logic [NUM_W-1:0] MAXN = NUM_W'(CELLS);
    localparam logic [PW-1:0] LAST = PW'(CELLS - 1);

    state_t st, st_n;

    logic [PW-1:0]    pos;
    logic [NV-1:0]    used;
    logic             fill;
    logic [CELLS-1:0] rx_hit, kb_hit, circ_set;
    logic [2*N+1:0]   line_done;
    logic [LW-1:0]    line_cnt;
    logic [NUM_W-1:0] low_free, place_val;
    logic             place, fill_start, tx_load, do_check, clear;
    logic             cur_ok, rx_ok, kb_ok, reset_any;

    logic [N-1:0][N-1:0] col_v;
    logic [N-1:0]        dg0, dg1;

    assign state     = st;
    assign reset_any = rst | interboard_rst;
    assign cur_ok    = (cur_number != '0) && (cur_number <= MAXN);

    // Hit vectors only flag uncircled cells, so "present and uncircled" is an OR-reduce.
    for (genvar i = 0; i < CELLS; i++) begin : g_hit
        assign rx_hit[i] = (map[i*NUM_W +: NUM_W] == rx_number)
                         && (rx_number != '0) && !circle[i];
        assign kb_hit[i] = (map[i*NUM_W +: NUM_W] == cur_number)
                         && (cur_number != '0) && !circle[i];
    end

    assign rx_ok = |rx_hit;
    assign kb_ok = |kb_hit;

    for (genvar r = 0; r < N; r++) begin : g_row
        assign line_done[r] = &circle[r*N +: N];
        assign dg0[r] = circle[r*N + r];
        assign dg1[r] = circle[r*N + N - 1 - r];
        for (genvar c = 0; c < N; c++) begin : g_col
            assign col_v[c][r] = circle[r*N + c];
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_cdone
        assign line_done[N + c] = &col_v[c];
    end

    assign line_done[2*N]   = &dg0;
    assign line_done[2*N+1] = &dg1;

    always_comb begin
        line_cnt = '0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            line_cnt = line_cnt + LW'(line_done[i]);
        end
    end

    always_comb begin
        low_free = '0;
        for (int k = CELLS; k >= 1; k--) begin
            if (!used[k]) low_free = NUM_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_any) st <= IDLE;
        else           st <= st_n;
    end

    always_comb begin
        st_n       = st;
        place      = 1'b0;
        place_val  = cur_number;
        fill_start = 1'b0;
        circ_set   = '0;
        tx_load    = 1'b0;
        do_check   = 1'b0;
        clear      = 1'b0;
        unique case (st)
            IDLE: begin
                if (start) begin
                    st_n  = SELECT;
                    clear = 1'b1;
                end
            end
            SELECT: begin
                if (fill) begin
                    place     = 1'b1;
                    place_val = low_free;
                    if (pos == LAST) st_n = PLAY;
                end else if (enter_pulse) begin
                    if (cur_ok && !used[cur_number]) begin
                        place = 1'b1;
                        if (pos == LAST) st_n = PLAY;
                    end
`ifdef BINGO_AUTOFILL_EN
                    else if (cur_number == '0) begin
                        fill_start = 1'b1;
                    end
`endif
                end
            end
            PLAY: begin
                if (rx_en && rx_ok) begin
                    circ_set = rx_hit;
                    st_n     = CHECK;
                end else if (enter_pulse && !tx_en && kb_ok) begin
                    circ_set = kb_hit;
                    tx_load  = 1'b1;
                    st_n     = CHECK;
                end
            end
            CHECK: begin
                do_check = 1'b1;
                st_n = (line_cnt >= LW'(WIN_LINES)) ? WIN : PLAY;
            end
            WIN: begin
                if (start) begin
                    st_n  = SELECT;
                    clear = 1'b1;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_any) begin
            map       <= '0;
            circle    <= '0;
            lines     <= '0;
            win       <= 1'b0;
            tx_en     <= 1'b0;
            tx_number <= '0;
            pos       <= '0;
            used      <= '0;
            fill      <= 1'b0;
        end else begin
            if (tx_en && tx_ready) tx_en <= 1'b0;
            if (tx_load) begin
                tx_en     <= 1'b1;
                tx_number <= cur_number;
            end
            // A pending tx deliberately survives a new game.
            if (clear) begin
                map    <= '0;
                circle <= '0;
                lines  <= '0;
                win    <= 1'b0;
                pos    <= '0;
                used   <= '0;
                fill   <= 1'b0;
            end else begin
                if (place) begin
                    map[int'(pos)*NUM_W +: NUM_W] <= place_val;
                    used[place_val] <= 1'b1;
                    pos <= pos + 1'b1;
                    if (pos == LAST) fill <= 1'b0;
                end
                if (fill_start) fill <= 1'b1;
                circle <= circle | circ_set;
                if (do_check) begin
                    lines <= line_cnt;
                    win   <= (line_cnt >= LW'(WIN_LINES));
                end
            end
        end
    end

endmodule

// File: tb/tb_bingo_board_engine.sv
// Self-checking bench for bingo_board_engine: vector table, directed corners, random vs model.
module tb_bingo_board_engine;

    localparam int N = 5;
    localparam int NUM_W = 5;
    localparam int CELLS = 25;
    localparam int LW = 4;

    logic clk;
    logic rst, interboard_rst, start, enter_pulse, rx_en, tx_ready;
    logic [NUM_W-1:0] cur_number, rx_number;
    logic tx_en;
    logic [NUM_W-1:0] tx_number;
    logic [CELLS*NUM_W-1:0] map;
    logic [CELLS-1:0] circle;
    logic [LW-1:0] lines;
    logic win;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // transaction-level model of the board
    int m_state;
    int board[CELLS];
    bit circ[CELLS];
    int m_pos;
    bit m_txen;
    int m_txnum;
    int m_lines;
    bit m_win;

    bingo_board_engine #(.N(N), .NUM_W(NUM_W), .WIN_LINES(3)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .start(start), .enter_pulse(enter_pulse), .cur_number(cur_number),
        .rx_en(rx_en), .rx_number(rx_number), .tx_ready(tx_ready),
        .tx_en(tx_en), .tx_number(tx_number), .map(map), .circle(circle),
        .lines(lines), .win(win), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < CELLS; i++) begin
            board[i] = 0;
            circ[i] = 0;
        end
        m_pos = 0;
        m_lines = 0;
        m_win = 0;
    endtask

    function automatic int find_cell(int num);
        if (num < 1) return -1;
        for (int i = 0; i < CELLS; i++) if (board[i] == num) return i;
        return -1;
    endfunction

    function automatic int count_lines();
        int cnt = 0;
        bit r, c, d0 = 1, d1 = 1;
        for (int a = 0; a < N; a++) begin
            r = 1;
            c = 1;
            for (int b = 0; b < N; b++) begin
                r &= circ[a*N + b];
                c &= circ[b*N + a];
            end
            cnt += r + c;
            d0 &= circ[a*N + a];
            d1 &= circ[a*N + N - 1 - a];
        end
        return cnt + d0 + d1;
    endfunction

    task automatic model_step();
        int idx;
        bit old_tx;
        old_tx = m_txen;
        if (rst || interboard_rst) begin
            m_state = 0;
            m_clear();
            m_txen = 0;
            m_txnum = 0;
            return;
        end
        if (old_tx && tx_ready) m_txen = 0;
        case (m_state)
            0, 4: if (start) begin
                m_clear();
                m_state = 1;
            end
            1: if (enter_pulse && cur_number >= 1 && cur_number <= CELLS
                   && find_cell(int'(cur_number)) < 0) begin
                board[m_pos] = int'(cur_number);
                m_pos++;
                if (m_pos == CELLS) m_state = 2;
            end
            2: begin
                idx = find_cell(int'(rx_number));
                if (rx_en && idx >= 0 && !circ[idx]) begin
                    circ[idx] = 1;
                    m_state = 3;
                end else begin
                    idx = find_cell(int'(cur_number));
                    if (enter_pulse && !old_tx && idx >= 0 && !circ[idx]) begin
                        circ[idx] = 1;
                        m_txen = 1;
                        m_txnum = int'(cur_number);
                        m_state = 3;
                    end
                end
            end
            3: begin
                m_lines = count_lines();
                m_win = (m_lines >= 3);
                m_state = m_win ? 4 : 2;
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic compare_all();
        logic [CELLS*NUM_W-1:0] em;
        logic [CELLS-1:0] ec;
        for (int i = 0; i < CELLS; i++) begin
            em[i*NUM_W +: NUM_W] = NUM_W'(board[i]);
            ec[i] = circ[i];
        end
        check("state", state, m_state[2:0]);
        check("map", map, em);
        check("circle", circle, ec);
        check("lines", lines, m_lines[LW-1:0]);
        check("win", win, m_win);
        check("tx_en", tx_en, m_txen);
        check("tx_number", tx_number, m_txnum[NUM_W-1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        start = 0;
        enter_pulse = 0;
        rx_en = 0;
        rst = 0;
        interboard_rst = 0;
    endtask

    task automatic press(int num);
        enter_pulse = 1;
        cur_number = NUM_W'(num);
        tick();
    endtask

    task automatic recv(int num);
        rx_en = 1;
        rx_number = NUM_W'(num);
        tick();
        tick();
    endtask

    task automatic new_game_in_order();
        rst = 1;
        tick();
        start = 1;
        tick();
        for (int k = 1; k <= CELLS; k++) press(k);
    endtask

    function automatic int filled_cells();
        int n = 0;
        for (int i = 0; i < CELLS; i++) if (map[i*NUM_W +: NUM_W] != 0) n++;
        return n;
    endfunction

    typedef struct {
        logic       st;
        logic       en;
        logic [4:0] num;
        int         exp_filled;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vt[8];
    int free_list[$];

    initial begin
        rst = 1;
        interboard_rst = 0;
        start = 0;
        enter_pulse = 0;
        cur_number = 0;
        rx_en = 0;
        rx_number = 0;
        tx_ready = 1;
        m_state = 0;
        m_txen = 0;
        m_txnum = 0;
        m_clear();

        vt[0] = '{1'b0, 1'b1, 5'd4,  0, 3'd0};
        vt[1] = '{1'b1, 1'b0, 5'd0,  0, 3'd1};
        vt[2] = '{1'b0, 1'b1, 5'd7,  1, 3'd1};
        vt[3] = '{1'b0, 1'b1, 5'd7,  1, 3'd1};
        vt[4] = '{1'b0, 1'b1, 5'd0,  1, 3'd1};
        vt[5] = '{1'b0, 1'b1, 5'd26, 1, 3'd1};
        vt[6] = '{1'b0, 1'b1, 5'd3,  2, 3'd1};
        vt[7] = '{1'b1, 1'b0, 5'd0,  2, 3'd1};

        @(negedge clk);
        tick();
        tick();
        check("reset_state", state, 3'd0);
        check("reset_map", map, '0);

        for (int i = 0; i < 8; i++) begin
            start = vt[i].st;
            enter_pulse = vt[i].en;
            cur_number = vt[i].num;
            tick();
            check("vec_filled", filled_cells(), vt[i].exp_filled);
            check("vec_state", state, vt[i].exp_state);
        end
        check("dup_cell0", map[4:0], 5'd7);

        new_game_in_order();
        check("order_state", state, 3'd2);
        check("order_cell24", map[24*5 +: 5], 5'd25);
        for (int k = 1; k <= 5; k++) recv(k);
        check("row_lines", lines, 4'd1);
        for (int k = 6; k <= 21; k += 5) recv(k);
        check("col_lines", lines, 4'd2);
        check("col_nowin", win, 1'b0);
        for (int k = 7; k <= 25; k += 6) recv(k);
        check("diag_lines", lines, 4'd3);
        check("diag_win", win, 1'b1);
        check("diag_state", state, 3'd4);
        recv(20);
        check("win_frozen", circle[19], 1'b0);

        new_game_in_order();
        rx_en = 1;
        rx_number = 9;
        enter_pulse = 1;
        cur_number = 10;
        tick();
        check("simul_rx", circle[8], 1'b1);
        check("simul_kb", circle[9], 1'b0);
        check("simul_tx", tx_en, 1'b0);
        tick();

        tx_ready = 0;
        press(12);
        for (int i = 0; i < 4; i++) begin
            check("tx_hold_en", tx_en, 1'b1);
            check("tx_hold_num", tx_number, 5'd12);
            tick();
        end
        press(13);
        check("tx_busy_drop", circle[12], 1'b0);
        tx_ready = 1;
        tick();
        check("tx_done", tx_en, 1'b0);

        interboard_rst = 1;
        tick();
        check("irst_state", state, 3'd0);
        check("irst_circle", circle, '0);
        check("irst_map", map, '0);
        check("irst_lines", lines, '0);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            tx_ready = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 499) == 0);
            start = (m_state == 0 || m_state == 4) ?
                ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
            enter_pulse = ($urandom_range(0, 2) == 0);
            cur_number = NUM_W'($urandom_range(0, 31));
            rx_en = ($urandom_range(0, 3) == 0);
            rx_number = NUM_W'($urandom_range(0, 27));
            if (m_state == 1 && $urandom_range(0, 3) != 0) begin
                free_list.delete();
                for (int k = 1; k <= CELLS; k++)
                    if (find_cell(k) < 0) free_list.push_back(k);
                cur_number = NUM_W'(free_list[$urandom_range(0, free_list.size() - 1)]);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
